// File: rtl/move_list_writer.sv
// move_list_writer: drains the LMG move FIFO after LMG is done, unpacks each
// FIFO word into move slots, writes the valid moves to consecutive RAM words
// from BASE_ADDR, then writes a {overflow, count} summary word at COUNT_ADDR.
module move_list_writer #(
  parameter int                    MOVE_WIDTH = 18,
  parameter int                    SLOTS      = 8,
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 15'h17,
  parameter logic [ADDR_WIDTH-1:0] COUNT_ADDR = 15'h16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                lmg_done,
  input  logic                                fifo_empty,
  output logic                                fifo_rden,
  input  logic [SLOTS*(MOVE_WIDTH+1)-1:0]     fifo_data,
  output logic                                ram_wren,
  output logic [ADDR_WIDTH-1:0]               ram_wraddr,
  output logic [DATA_WIDTH-1:0]               ram_data,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               move_count,
  output logic                                overflow
);

  localparam int SLOT_W  = MOVE_WIDTH + 1;
  localparam int WORD_W  = SLOTS * SLOT_W;
  localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PAD_W   = DATA_WIDTH - 1 - ADDR_WIDTH;
  localparam int MAX_INT = (1 << ADDR_WIDTH) - int'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = MAX_INT[ADDR_WIDTH-1:0];
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(SLOTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_LOAD, S_SCAN, S_SUMMARY, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [IDX_W-1:0]        slot_q, slot_d;
  logic                    fifo_rden_q, fifo_rden_d;
  logic                    ram_wren_q, ram_wren_d;
  logic [ADDR_WIDTH-1:0]   ram_wraddr_q, ram_wraddr_d;
  logic [DATA_WIDTH-1:0]   ram_data_q, ram_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   move_count_q, move_count_d;
  logic                    overflow_q, overflow_d;

  // Slot views of the incoming FIFO word and of the captured word.
  logic [SLOTS-1:0]        in_invalid;
  logic [SLOTS-1:0]        word_valid;
  logic [MOVE_WIDTH-1:0]   word_move [SLOTS];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign in_invalid[gi] = fifo_data[gi*SLOT_W + MOVE_WIDTH];
    assign word_valid[gi] = ~word_q[gi*SLOT_W + MOVE_WIDTH];
    assign word_move[gi]  = word_q[gi*SLOT_W +: MOVE_WIDTH];
  end

  logic                  cur_valid;
  logic [MOVE_WIDTH-1:0] cur_move;
  assign cur_valid = word_valid[slot_q];
  assign cur_move  = word_move[slot_q];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the REQ decision uses the pop already registered on entry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start)    state_d = S_WAIT;
      S_WAIT:         if (lmg_done) state_d = S_REQ;
      S_REQ:          state_d = fifo_rden_q ? S_LOAD : S_SUMMARY;
      S_LOAD:         state_d = (&in_invalid) ? S_SUMMARY : S_SCAN;
      S_SCAN:         if (slot_q == LAST_IDX) state_d = S_REQ;
      S_SUMMARY:      state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. The FIFO empty flag is sampled on entry to
  // REQ so the pop strobe can be a register that is high during REQ itself.
  always_comb begin
    fifo_rden_d  = (state_d == S_REQ) && !fifo_empty;
    busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE));
    ram_wren_d   = 1'b0;
    ram_wraddr_d = ram_wraddr_q;
    ram_data_d   = ram_data_q;
    done_d       = done_q;
    move_count_d = move_count_q;
    overflow_d   = overflow_q;
    word_d       = word_q;
    slot_d       = slot_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          move_count_d = '0;
          overflow_d   = 1'b0;
          done_d       = 1'b0;
        end else if (state_q == S_DONE) begin
          done_d = 1'b1;
        end
      end
      S_LOAD: begin
        word_d = fifo_data;
        slot_d = '0;
      end
      S_SCAN: begin
        slot_d = slot_q + IDX_W'(1);
        if (cur_valid) begin
          if (move_count_q < MAX_COUNT) begin
            ram_wren_d   = 1'b1;
            ram_wraddr_d = BASE_ADDR + move_count_q;
            ram_data_d   = {{(DATA_WIDTH-MOVE_WIDTH){1'b0}}, cur_move};
            move_count_d = move_count_q + ADDR_WIDTH'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_SUMMARY: begin
        ram_wren_d   = 1'b1;
        ram_wraddr_d = COUNT_ADDR;
        ram_data_d   = {overflow_q, {PAD_W{1'b0}}, move_count_q};
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q       <= '0;
      slot_q       <= '0;
      fifo_rden_q  <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_wraddr_q <= '0;
      ram_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      move_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      word_q       <= word_d;
      slot_q       <= slot_d;
      fifo_rden_q  <= fifo_rden_d;
      ram_wren_q   <= ram_wren_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_data_q   <= ram_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      move_count_q <= move_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_rden  = fifo_rden_q;
  assign ram_wren   = ram_wren_q;
  assign ram_wraddr = ram_wraddr_q;
  assign ram_data   = ram_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign move_count = move_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_move_list_writer.sv
// Testbench for move_list_writer: a behavioural FIFO feeds words, a monitor
// logs RAM writes, and a list-level reference model predicts the writes.
module tb_move_list_writer;
  localparam int MW = 18;
  localparam int SL = 8;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int WW = SL * (MW + 1);
  localparam int MAXC = 32745;

  logic          clk = 1'b0;
  logic          reset, start, lmg_done;
  logic          fifo_empty, fifo_rden, ram_wren, busy, done, overflow;
  logic [WW-1:0] fifo_data = '0;
  logic [AW-1:0] ram_wraddr, move_count;
  logic [DW-1:0] ram_data;

  always #5 clk = ~clk;

  move_list_writer dut (
    .clk(clk), .reset(reset), .start(start), .lmg_done(lmg_done),
    .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .fifo_data(fifo_data),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_data(ram_data),
    .busy(busy), .done(done), .move_count(move_count), .overflow(overflow)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // Behavioural FIFO: pop seen during the cycle, data presented the next cycle.
  logic [WW-1:0] mem [1024];
  int            wr_ptr = 0, rd_ptr = 0, pops = 0;
  int            flush_gen = 0, flush_seen = 0;
  bit            pending = 1'b0;
  logic [WW-1:0] pend_word = '0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    #1;
    if (flush_gen != flush_seen) begin
      rd_ptr = wr_ptr; flush_seen = flush_gen; pending = 1'b0;
    end
    if (pending) begin fifo_data = pend_word; pending = 1'b0; end
    if (fifo_rden) begin
      pend_word = mem[rd_ptr % 1024]; rd_ptr++; pops++; pending = 1'b1;
    end
  end

  // RAM write log.
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  always @(posedge clk) begin
    #1;
    if (ram_wren) begin log_addr.push_back(ram_wraddr); log_data.push_back(ram_data); end
  end

  logic [WW-1:0] mw[$];   // words of the current list, as loaded into the FIFO

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] set_slot(input logic [WW-1:0] w, input int s,
                                             input bit valid, input logic [MW-1:0] mv);
    logic [WW-1:0] r = w;
    r[s*(MW+1) +: MW] = mv;
    r[s*(MW+1) + MW]  = ~valid;
    return r;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w = '0;
    bit any = 0;
    for (int s = 0; s < SL; s++) begin
      bit v = bit'($urandom_range(0, 1));
      any |= v;
      w = set_slot(w, s, v, MW'($urandom));
    end
    if (!any) w = set_slot(w, $urandom_range(0, SL-1), 1'b1, MW'($urandom));
    return w;
  endfunction

  function automatic logic [WW-1:0] term_word();
    logic [WW-1:0] w = '0;
    for (int s = 0; s < SL; s++) w = set_slot(w, s, 1'b0, MW'($urandom));
    return w;
  endfunction

  task automatic gen_random(input int nwords, input bit term);
    mw.delete();
    for (int i = 0; i < nwords; i++) mw.push_back(rand_word());
    if (term) mw.push_back(term_word());
  endtask

  task automatic load_fifo();
    foreach (mw[i]) begin mem[wr_ptr % 1024] = mw[i]; wr_ptr++; end
  endtask

  task automatic flush_fifo();
    flush_gen++;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(1));
  endtask

  function automatic logic [63:0] log_a(input int idx);
    return (idx < log_addr.size()) ? 64'(log_addr[idx]) : 'x;
  endfunction
  function automatic logic [63:0] log_d(input int idx);
    return (idx < log_data.size()) ? 64'(log_data[idx]) : 'x;
  endfunction

  // Reference: walk the list word by word, slot by slot, with a capped counter.
  task automatic check_list(input string tag, input int lb, input int pb, input int preload);
    int            cnt = preload;
    bit            ovf = 0;
    int            np = 0;
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    foreach (mw[w]) begin
      int nvalid = 0;
      np++;
      for (int s = 0; s < SL; s++) if (!mw[w][s*(MW+1) + MW]) nvalid++;
      if (nvalid == 0) break;
      for (int s = 0; s < SL; s++) begin
        if (!mw[w][s*(MW+1) + MW]) begin
          if (cnt < MAXC) begin
            ea.push_back(AW'(23 + cnt));
            ed.push_back(DW'(mw[w][s*(MW+1) +: MW]));
            cnt++;
          end else ovf = 1;
        end
      end
    end
    ea.push_back(AW'(22));
    ed.push_back(DW'(cnt) + (ovf ? 32'h8000_0000 : 32'h0));
    check({tag, "_nwrites"}, 64'(log_addr.size() - lb), 64'(ea.size()));
    foreach (ea[i]) begin
      check($sformatf("%s_addr%0d", tag, i), log_a(lb + i), 64'(ea[i]));
      check($sformatf("%s_data%0d", tag, i), log_d(lb + i), 64'(ed[i]));
    end
    check({tag, "_pops"}, 64'(pops - pb), 64'(np));
    check({tag, "_count"}, 64'(move_count), 64'(cnt));
    check({tag, "_overflow"}, 64'(overflow), 64'(ovf));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lb, pb;
    logic [WW-1:0] w;
    reset = 1'b0; start = 1'b0; lmg_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({fifo_rden, ram_wren, busy, done, overflow, move_count}), 64'(0));
    check("reset_data", 64'({ram_wraddr, ram_data}), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single word plus terminator.
    w = '0;
    for (int s = 0; s < SL; s++) w = set_slot(w, s, 1'b0, '0);
    w = set_slot(w, 0, 1'b1, 18'h00012);
    w = set_slot(w, 2, 1'b1, 18'h00345);
    mw.delete(); mw.push_back(w); mw.push_back(term_word());
    load_fifo();
    lb = log_addr.size(); pb = pops;
    lmg_done = 1'b1;
    pulse_start();
    wait_done("t1");
    check_list("t1", lb, pb, 0);
    check("t1_w0", {log_a(lb), log_d(lb)}, {64'h17, 64'h12});
    check("t1_w1", {log_a(lb+1), log_d(lb+1)}, {64'h18, 64'h345});
    check("t1_sum", {log_a(lb+2), log_d(lb+2)}, {64'h16, 64'h2});

    // Wait on LMG.
    lmg_done = 1'b0;
    gen_random(1, 1'b1); load_fifo();
    lb = log_addr.size(); pb = pops;
    pulse_start();
    repeat (20) @(negedge clk);
    check("t2_no_pop", 64'(pops - pb), 64'(0));
    check("t2_busy_wait", 64'(busy), 64'(1));
    lmg_done = 1'b1;
    @(negedge clk);
    check("t2_first_pop", 64'(fifo_rden), 64'(1));
    wait_done("t2");
    check_list("t2", lb, pb, 0);

    // Empty FIFO.
    flush_fifo();
    mw.delete();
    lb = log_addr.size(); pb = pops;
    pulse_start();
    wait_done("t3");
    check_list("t3", lb, pb, 0);

    // Overflow with a preloaded count.
    lmg_done = 1'b0;
    w = '0;
    for (int s = 0; s < SL; s++) w = set_slot(w, s, (s == 0 || s == 3 || s == 5), MW'($urandom));
    mw.delete(); mw.push_back(w); mw.push_back(term_word());
    load_fifo();
    lb = log_addr.size(); pb = pops;
    pulse_start();
    force dut.move_count_q = 15'd32744;
    @(posedge clk);
    #1 release dut.move_count_q;
    @(negedge clk) lmg_done = 1'b1;
    wait_done("t4");
    check_list("t4", lb, pb, 32744);
    check("t4_addr", log_a(lb), 64'h7FFF);
    check("t4_sum", log_d(lb+1), 64'h8000_7FE9);

    // Reset in the middle of scanning word 0 (slot 4).
    flush_fifo();
    w = '0;
    for (int s = 0; s < SL; s++) w = set_slot(w, s, 1'b1, MW'($urandom));
    mw.delete(); mw.push_back(w); mw.push_back(term_word());
    load_fifo();
    lb = log_addr.size();
    pulse_start();
    for (int i = 0; i < 200 && log_addr.size() < lb + 4; i++) @(negedge clk);
    check("t5_at_slot4", 64'(log_addr.size() - lb), 64'(4));
    reset = 1'b0;
    #1;
    check("t5_rst_ctrl", 64'({fifo_rden, ram_wren, busy, done, overflow, move_count}), 64'(0));
    check("t5_rst_data", 64'({ram_wraddr, ram_data}), 64'(0));
    @(negedge clk);
    check("t5_no_summary", 64'(log_addr.size() - lb), 64'(4));
    reset = 1'b1;
    flush_fifo();
    gen_random(2, 1'b1); load_fifo();
    lb = log_addr.size(); pb = pops;
    pulse_start();
    wait_done("t5b");
    check_list("t5b", lb, pb, 0);
    check("t5b_first_addr", log_a(lb), 64'h17);

    // Restart from DONE.
    flush_fifo();
    gen_random(3, 1'b1); load_fifo();
    lb = log_addr.size(); pb = pops;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t6_done_clr", 64'(done), 64'(0));
    check("t6_count_clr", 64'(move_count), 64'(0));
    wait_done("t6");
    check_list("t6", lb, pb, 0);

    // Randomised lists, with and without a terminator word.
    for (int k = 0; k < 6; k++) begin
      flush_fifo();
      gen_random($urandom_range(0, 4), bit'($urandom_range(0, 1)));
      load_fifo();
      lb = log_addr.size(); pb = pops;
      pulse_start();
      wait_done($sformatf("r%0d", k));
      check_list($sformatf("r%0d", k), lb, pb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/move_list_writer.md
# move_list_writer

Sits between the LMG move FIFO and the control block's One_Mib_RAM write port. After LMG signals done, it pops 152-bit FIFO words, unpacks each into eight 19-bit move slots, and writes only the valid 18-bit moves to consecutive RAM entries from `BASE_ADDR` upward. It then writes the move count and overflow flag to `COUNT_ADDR` and raises `done` for the Avalon-side control logic.

## Interface
- `MOVE_WIDTH`, 18: move field width per slot; slot width is `MOVE_WIDTH+1`.
- `SLOTS`, 8: move slots per FIFO word.
- `ADDR_WIDTH`, 15: RAM address width.
- `DATA_WIDTH`, 32: RAM data width.
- `BASE_ADDR`, 15'h17: RAM address of the first move.
- `COUNT_ADDR`, 15'h16: RAM address of the summary word.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request to begin a new list.
- `lmg_done` in 1: LMG has finished filling the FIFO (level).
- `fifo_empty` in 1: LMG FIFO empty flag.
- `fifo_rden` out 1: FIFO pop. Data is valid on `fifo_data` the cycle after the pop.
- `fifo_data` in `SLOTS*(MOVE_WIDTH+1)`: FIFO word. Slot i = bits [19i+18:19i]; bit 19i+18 is the invalid flag (1 = invalid).
- `ram_wren` out 1: RAM write strobe.
- `ram_wraddr` out `ADDR_WIDTH`: RAM write address.
- `ram_data` out `DATA_WIDTH`: RAM write data.
- `busy` out 1: high in any state other than IDLE and DONE.
- `done` out 1: list complete and summary written.
- `move_count` out `ADDR_WIDTH`: valid moves written so far.
- `overflow` out 1: sticky; at least one valid move was dropped.

## Operation
- States: IDLE, WAIT, REQ, LOAD, SCAN, SUMMARY, DONE.
- **IDLE / DONE**
  - `start` → WAIT.
  - The same edge clears `move_count`, `overflow` and `done`.
- **WAIT**
  - `lmg_done`=1 → REQ.
  - Otherwise hold.
- **REQ**
  - `fifo_empty`=1 → SUMMARY, no pop.
  - Otherwise assert `fifo_rden` for exactly one cycle → LOAD.
- **LOAD**
  - Capture `fifo_data` into the word register and clear the slot index.
  - All eight invalid flags set (terminator word) → SUMMARY.
  - Otherwise → SCAN.
- **SCAN** (one slot per cycle, index 0..7, valid or not)
  - Slot valid and `move_count` < `MAX` (`MAX = 2^ADDR_WIDTH - BASE_ADDR` = 32745):
    - write `ram_wraddr` = `BASE_ADDR` + `move_count`;
    - write `ram_data` = zero-extended move;
    - increment `move_count`.
  - Slot valid and `move_count` = `MAX`: no write; set `overflow`.
  - Slot invalid: no write.
  - After slot 7 → REQ.
- **SUMMARY**
  - One write: `ram_wraddr` = `COUNT_ADDR`, `ram_data` = {`overflow`, 16'b0, `move_count`}.
  - → DONE.
- **DONE**
  - `done`=1; holds until `start` or reset.
- `start` in WAIT, REQ, LOAD, SCAN or SUMMARY is ignored.
- `lmg_done` is sampled only in WAIT.
- Address arithmetic is `ADDR_WIDTH` wide. It never wraps, because the `MAX` cap stops writes first.

## Timing
- Reset values: state IDLE.
  - All outputs 0: `fifo_rden`, `ram_wren`, `ram_wraddr`, `ram_data`, `busy`, `done`, `move_count`, `overflow`.
  - Reset asserted mid-list aborts immediately; no summary write occurs.
- All outputs are registered.
- A slot's RAM write appears in the cycle after that slot occupies SCAN. The `move_count` increment appears in the same cycle as the write.
- Per non-terminator word: 10 cycles (REQ 1, LOAD 1, SCAN 8).
- Terminator word: 2 cycles, then SUMMARY.
- The summary write is visible the cycle after SUMMARY. `done` rises one cycle after the summary write.
- Write strobes are at most one per cycle. `ram_wren` and `fifo_rden` are never high for two consecutive pops of the same word.
- `start` arriving in the same cycle as the transition into DONE is ignored.

## Test plan
- **Single word plus terminator.**
  - Stimulus: `start`; `lmg_done`=1. Word 0 has slots 0 and 2 valid, moves 0x00012 and 0x00345; other slots invalid. Word 1 all invalid.
  - Required: writes 0x17←0x12, then 0x18←0x345, then 0x16←0x00000002. `done`=1; exactly 2 `fifo_rden` pulses.
- **Wait on LMG.**
  - Stimulus: `start`; `lmg_done` held low 20 cycles, then high.
  - Required: no `fifo_rden` before `lmg_done`. First pop occurs 1 cycle after `lmg_done` is sampled in WAIT.
- **Empty FIFO.**
  - Stimulus: `fifo_empty`=1 at the first REQ.
  - Required: no pop; 0x16←0; `done`=1; `move_count`=0.
- **Overflow.**
  - Stimulus: preload `move_count` to 32744 via a force/backdoor; then one word with 3 valid moves.
  - Required: one write at 0x7FFF; `overflow`=1; summary = 0x80007FE9.
- **Reset mid-SCAN.**
  - Stimulus: assert `reset` low at slot 4 of word 0.
  - Required: all outputs 0 asynchronously; next `start` restarts at address 0x17 with count 0.
- **Restart from DONE.**
  - Stimulus: `start` while `done`=1.
  - Required: `done` and `move_count` clear the next cycle; a second list writes from 0x17 again.
